md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO result registers, driven from the EX stage.
//  It accepts MULT/DIV operands from EX (forwarded rs/rt) and runs for multiple cycles, raising busy while it works.
//  EX stall detection holds any MD op or HI/LO read (MFHI/MFLO) while busy.
//  Width and bits-per-cycle are parametrised. It adds signed/unsigned division, abort, and defined divide-by-zero results.
// PARAMETERS
//  WIDTH      32  operand width; HI and LO are each WIDTH bits
//  STEP_BITS  1   quotient/product bits retired per cycle; must be 1, 2 or 4 and divide WIDTH
// PORTS
//  clk     in   1      clock
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      EX issues an op this cycle; sampled only when func != MD_NONE
//  func    in   3      md_func_t: NONE=0, MUL=1, DIV=2, MTHI=3, MTLO=4; other codes are treated as NONE
//  is_sign in   1      1 = signed MUL/DIV, 0 = unsigned
//  a       in   WIDTH  rs operand (multiplicand / dividend / MTHI, MTLO source)
//  b       in   WIDTH  rt operand (multiplier / divisor)
//  cancel  in   1      abort the in-flight MUL/DIV (EX_FLUSH of the issuing slot)
//  busy    out  1      iteration in progress; EX must not issue and must not read HI/LO
//  done    out  1      one-cycle pulse: HI/LO were just updated by a MUL/DIV
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; busy=0, done=0, hi=0, lo=0; all working registers cleared.
//  - Accept: on a clk edge with start=1, busy=0, cancel=0.
//    - If busy=1, start is ignored; no queueing.
//  - MTHI/MTLO: hi (or lo) <= a at the accept edge. busy stays 0 and done stays 0 (1-cycle op).
//  - MUL/DIV at accept: latch |a| and |b| (magnitudes when is_sign=1), then capture the result-sign flags:
//    - MUL: neg = sign(a) XOR sign(b).
//    - DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
//  - FSM states: IDLE -> ITER -> FIX -> IDLE.
//    - ITER runs ITER_N = WIDTH/STEP_BITS cycles, counted by cnt (ITER_N-1 down to 0).
//    - FIX runs 1 cycle: two's-complement correction of the magnitude result.
//    - At the edge leaving FIX: {hi,lo} <= result, done=1 for the following cycle, busy=0.
//    - busy is high for exactly ITER_N+1 cycles after the accept edge (33 for 32/1).
//  - MUL: shift-add over a 2*WIDTH accumulator; {hi,lo} = full 2*WIDTH product.
//  - DIV: restoring division, STEP_BITS quotient bits per cycle; lo = quotient, hi = remainder.
//  - Divide by zero (b==0): lo = all-ones, hi = a. Decided at accept; the unit still takes the full ITER_N+1 cycles.
//  - Signed overflow (a = min negative, b = -1): lo = a, hi = 0; needs no special path if magnitudes are WIDTH+1 bits.
//  - cancel=1 while busy: return to IDLE at the next edge; busy=0, done=0, hi/lo unchanged.
//    - cancel during the FIX cycle also suppresses the write.
//    - cancel in the same cycle as start: start is not accepted.
//  - done and a new accept may coincide: the accept in the done cycle is legal because busy is already 0.
//  - rst mid-operation: immediate IDLE, hi/lo cleared.
//  - The unit holds no pipeline ordering; EX stall logic guarantees no HI/LO read while busy.
// STRUCTURE
//  - md_pkg: md_func_t enum, md_state_t {IDLE, ITER, FIX}, and the ITER_N / counter-width functions.
//  - Sub-module md_div_step: combinational STEP_BITS-wide restoring step (rem, divisor -> rem', qbits).
//    It is instantiated once in md_unit. The multiply step stays inline.
// TESTING
//  1. MUL unsigned 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles, then done; hi=0xFFFFFFFE, lo=0x00000001.
//  2. MUL signed -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; the same operands with is_sign=0 -> hi=0x00000006, lo=0xFFFFFFEB.
//  3. DIV signed -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 0x80000000/0xFFFFFFFF signed -> lo=0x80000000, hi=0.
//  4. DIV 5/0 -> lo=0xFFFFFFFF, hi=5, full latency.
//     MTHI 0x1234 while idle -> hi=0x1234 next cycle, busy never asserted.
//  5. Start MUL, assert cancel at iteration 10 -> busy low next cycle, no done, hi/lo keep prior values.
//     A start issued while busy is ignored.
//  6. Assert rst mid-DIV -> outputs zero immediately (async).
//     Back-to-back: a new MUL accepted in the done cycle -> second result after another 33 cycles.
//     Repeat 1-4 with STEP_BITS=2 (busy 17 cycles) and STEP_BITS=4 (busy 9 cycles).

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_MTHI = 3'd3,
        MD_MTLO = 3'd4
    } md_func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    function automatic int iter_n(input int width, input int step);
        return width / step;
    endfunction

    function automatic int cnt_w(input int width, input int step);
        return (width / step > 1) ? $clog2(width / step) : 1;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// Combinational restoring-division step retiring STEP_BITS quotient bits.
module md_div_step #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic [WIDTH-1:0]     rem_i,
    input  logic [STEP_BITS-1:0] bits_i,
    input  logic [WIDTH-1:0]     dvsr_i,
    output logic [WIDTH-1:0]     rem_o,
    output logic [STEP_BITS-1:0] q_o
);

    logic [WIDTH:0] w_r;

    // rem_i < dvsr_i holds between steps, so the shifted-out MSB is always zero
    always_comb begin
        w_r = {1'b0, rem_i};
        q_o = '0;
        for (int i = STEP_BITS - 1; i >= 0; i--) begin
            w_r = {w_r[WIDTH-1:0], bits_i[i]};
            if (w_r >= {1'b0, dvsr_i}) begin
                w_r    = w_r - {1'b0, dvsr_i};
                q_o[i] = 1'b1;
            end
        end
        rem_o = w_r[WIDTH-1:0];
    end

endmodule

// File: rtl/md_unit.sv
// Iterative MUL/DIV unit with HI/LO registers; sign handled by magnitude
// iteration followed by a one-cycle two's-complement fix-up.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic             is_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER_N = iter_n(WIDTH, STEP_BITS);
    localparam int CW     = cnt_w(WIDTH, STEP_BITS);
    localparam logic [CW-1:0] CNT_INIT = CW'(ITER_N - 1);

    md_state_t            r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd, r_araw, r_hi, r_lo;
    logic                 r_is_div, r_neg_q, r_neg_r, r_dz, r_done;
    logic                 w_busy, w_write, w_accept, w_md_op, w_sa, w_sb;
    logic [WIDTH-1:0]     w_ma, w_mb, w_rem, w_quo_f, w_rem_f;
    logic [STEP_BITS-1:0] w_q;
    logic [WIDTH+STEP_BITS-1:0] w_psum;
    logic [2*WIDTH-1:0]   w_prod_f, w_res;

    assign w_sa     = is_sign & a[WIDTH-1];
    assign w_sb     = is_sign & b[WIDTH-1];
    assign w_ma     = w_sa ? -a : a;
    assign w_mb     = w_sb ? -b : b;
    assign w_accept = start & ~w_busy & ~cancel;
    assign w_md_op  = w_accept & ((func == MD_MUL) | (func == MD_DIV));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_md_op) w_next = ST_ITER;
            ST_ITER: if (cancel) w_next = ST_IDLE;
                     else if (r_cnt == '0) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_write = (r_state == ST_FIX) & ~cancel;
    end

    // Multiply: low half holds the remaining multiplier, high half the running sum
    assign w_psum = (WIDTH+STEP_BITS)'(r_acc[2*WIDTH-1:WIDTH])
                  + (WIDTH+STEP_BITS)'(r_opnd) * (WIDTH+STEP_BITS)'(r_acc[STEP_BITS-1:0]);

    md_div_step #(.WIDTH(WIDTH), .STEP_BITS(STEP_BITS)) u_div_step (
        .rem_i  (r_acc[2*WIDTH-1:WIDTH]),
        .bits_i (r_acc[WIDTH-1 -: STEP_BITS]),
        .dvsr_i (r_opnd),
        .rem_o  (w_rem),
        .q_o    (w_q)
    );

    assign w_prod_f = r_neg_q ? -r_acc : r_acc;
    assign w_quo_f  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_f  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_res    = r_dz ? {r_araw, {WIDTH{1'b1}}} :
                      r_is_div ? {w_rem_f, w_quo_f} : w_prod_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_araw   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_md_op) begin
                r_cnt    <= CNT_INIT;
                r_is_div <= (func == MD_DIV);
                r_opnd   <= (func == MD_DIV) ? w_mb : w_ma;
                r_acc    <= {{WIDTH{1'b0}}, (func == MD_DIV) ? w_ma : w_mb};
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_dz     <= (func == MD_DIV) & (b == '0);
                r_araw   <= a;
            end else if (r_state == ST_ITER) begin
                r_cnt <= r_cnt - 1'b1;
                r_acc <= r_is_div ? {w_rem, r_acc[WIDTH-STEP_BITS-1:0], w_q}
                                  : {w_psum, r_acc[WIDTH-1:STEP_BITS]};
            end
            if (w_accept && func == MD_MTHI) r_hi <= a;
            if (w_accept && func == MD_MTLO) r_lo <= a;
            if (w_write) {r_hi, r_lo} <= w_res;
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Drives three md_unit instances (STEP_BITS 1/2/4) with shared stimulus and
// compares against an arithmetic reference model.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func = 3'd0;
    logic        is_sign = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic [2:0]  busy_v, done_v;
    logic [31:0] hi_v [3];
    logic [31:0] lo_v [3];

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] exp_hl = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        md_unit #(.WIDTH(32), .STEP_BITS(1 << g)) u_dut (
            .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign),
            .a(a), .b(b), .cancel(cancel), .busy(busy_v[g]), .done(done_v[g]),
            .hi(hi_v[g]), .lo(lo_v[g]));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] f, input bit s,
                                           input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ux, uy;
        longint sx, sy, q, r;
        ux = s ? {{32{x[31]}}, x} : {32'b0, x};
        uy = s ? {{32{y[31]}}, y} : {32'b0, y};
        sx = longint'(ux);
        sy = longint'(uy);
        if (f == MD_MUL) return ux * uy;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic drive(input logic [2:0] f, input bit s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; func = f; is_sign = s; a = x; b = y;
    endtask

    // Called right after drive(); the following posedge is the accept edge.
    task automatic watch(input logic [63:0] exp, input bit junk, input string tag);
        int bc [3];
        int dat [3];
        int dn [3];
        for (int i = 0; i < 3; i++) begin bc[i] = 0; dat[i] = 0; dn[i] = 0; end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (junk && k == 3) drive(MD_MUL, 1'b0, $urandom, $urandom);
            if (junk && k == 4) start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) bc[i]++;
                if (done_v[i]) begin dn[i]++; dat[i] = k; end
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), 64'(bc[i]), 64'((32 >> i) + 1));
            chk($sformatf("%s_donecnt%0d", tag, i), 64'(dn[i]), 64'd1);
            chk($sformatf("%s_doneat%0d", tag, i), 64'(dat[i]), 64'((32 >> i) + 2));
            chk($sformatf("%s_hilo%0d", tag, i), {hi_v[i], lo_v[i]}, exp);
        end
        exp_hl = exp;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] x, y;
        bit          s;
        int          k, dn;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_out%0d", i), {30'd0, busy_v[i], done_v[i], hi_v[i], lo_v[i]}, 64'd0);
        rst = 1'b0;

        @(negedge clk); drive(MD_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch(64'hFFFF_FFFE_0000_0001, 1'b0, "mul_uu");
        @(negedge clk); drive(MD_MUL, 1'b1, -32'sd3, 32'd7);
        watch(64'hFFFF_FFFF_FFFF_FFEB, 1'b1, "mul_s");
        @(negedge clk); drive(MD_MUL, 1'b0, -32'sd3, 32'd7);
        watch(64'h0000_0006_FFFF_FFEB, 1'b0, "mul_u");
        @(negedge clk); drive(MD_DIV, 1'b1, -32'sd7, 32'd2);
        watch(64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_s");
        @(negedge clk); drive(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(64'h0000_0000_8000_0000, 1'b0, "div_ovf");
        @(negedge clk); drive(MD_DIV, 1'b0, 32'd5, 32'd0);
        watch(64'h0000_0005_FFFF_FFFF, 1'b0, "div_z");
        @(negedge clk); drive(MD_DIV, 1'b1, 32'hFFFF_FFF0, 32'd0);
        watch(64'hFFFF_FFF0_FFFF_FFFF, 1'b1, "div_zs");

        for (int n = 0; n < 24; n++) begin
            f = ($urandom_range(0, 1) == 0) ? MD_MUL : MD_DIV;
            s = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'd0;
                1: y = $urandom_range(1, 15);
                2: y = -$urandom_range(1, 5);
                default: y = $urandom;
            endcase
            @(negedge clk); drive(f, s, x, y);
            watch(ref_md(f, s, x, y), 1'(n & 1), $sformatf("rnd%0d", n));
        end

        // Register moves complete at the accept edge without going busy
        @(negedge clk); drive(MD_MTHI, 1'b0, 32'h0000_1234, 32'd0);
        @(negedge clk); start = 1'b0;
        exp_hl[63:32] = 32'h0000_1234;
        for (int i = 0; i < 3; i++)
            chk($sformatf("mthi%0d", i), {29'd0, busy_v[i], done_v[i], 1'b0, hi_v[i], lo_v[i]},
                {32'd0, exp_hl});
        x = $urandom;
        @(negedge clk); drive(MD_MTLO, 1'b0, x, 32'd0);
        @(negedge clk); start = 1'b0;
        exp_hl[31:0] = x;
        for (int i = 0; i < 3; i++)
            chk($sformatf("mtlo%0d", i), {29'd0, busy_v[i], done_v[i], 1'b0, hi_v[i], lo_v[i]},
                {32'd0, exp_hl});

        // Cancel mid-iteration; at cycle 9 the STEP_BITS=4 unit is in its FIX cycle
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); drive(MD_MUL, 1'b0, $urandom | 32'h1, $urandom | 32'h1);
            for (k = 1; k <= (c == 0 ? 5 : 9); k++) begin
                @(negedge clk);
                if (k == 1) start = 1'b0;
            end
            cancel = 1'b1;
            @(negedge clk); cancel = 1'b0;
            chk($sformatf("cancel%0d_busy", c), {61'd0, busy_v}, 64'd0);
            dn = 0;
            repeat (6) begin @(negedge clk); dn += int'(done_v != 3'b000); end
            chk($sformatf("cancel%0d_done", c), 64'(dn), 64'd0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("cancel%0d_hilo%0d", c, i), {hi_v[i], lo_v[i]}, exp_hl);
        end

        @(negedge clk); drive(MD_MUL, 1'b0, 32'd3, 32'd3); cancel = 1'b1;
        @(negedge clk); start = 1'b0; cancel = 1'b0;
        chk("cancel_start_busy", {61'd0, busy_v}, 64'd0);

        // Back-to-back: next MUL issued in the done cycle of the slowest unit
        @(negedge clk); drive(MD_MUL, 1'b1, 32'd1000, -32'sd9);
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done_v[0]) break;
        end
        chk("b2b_first_doneat", 64'(k), 64'd34);
        chk("b2b_first_hilo", {hi_v[0], lo_v[0]}, ref_md(MD_MUL, 1'b1, 32'd1000, -32'sd9));
        x = $urandom; y = $urandom;
        drive(MD_MUL, 1'b0, x, y);
        watch(ref_md(MD_MUL, 1'b0, x, y), 1'b0, "b2b");

        // Async reset mid-divide clears outputs without a clock edge
        @(negedge clk); drive(MD_DIV, 1'b0, 32'hDEAD_BEEF, 32'd7);
        repeat (4) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_mid%0d", i), {30'd0, busy_v[i], done_v[i], hi_v[i], lo_v[i]}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); drive(MD_DIV, 1'b0, 32'd100, 32'd7);
        watch(64'h0000_0002_0000_000E, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
